// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-port memory arbiter: arbiter states, port indices
// and the per-port byte-enable width.
package mem_arb_pkg;

    typedef enum logic {
        OPEN  = 1'b0,
        LOCK1 = 1'b1
    } arb_state_e;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_DMA = 1'b1;
    localparam int   BE_W     = 4;

endpackage

// File: rtl/arb_lock_counter.sv
// Saturating count of consecutive locked DMA grants, plus the one-cycle flag that
// hands the cycle after a forced release to the CPU port.
module arb_lock_counter #(
    parameter int LOCK_MAX = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clr_s,
    input  logic load_s,
    input  logic inc_s,
    output logic at_last_s,
    output logic prefer_cpu_q
);
    localparam int            CW    = $clog2(LOCK_MAX + 1);
    localparam logic [CW-1:0] MAX_C = CW'(LOCK_MAX);
    localparam logic [CW-1:0] ONE_C = CW'(1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          prefer_cpu_d;

    // The next locked grant would bring the count to LOCK_MAX.
    assign at_last_s = (cnt_q >= (MAX_C - ONE_C));

    // Next count and release flag; load wins over increment, which wins over clear.
    always_comb begin
        cnt_d        = cnt_q;
        prefer_cpu_d = 1'b0;
        if (load_s) begin
            cnt_d        = ONE_C;
            prefer_cpu_d = (LOCK_MAX <= 1);
        end else if (inc_s) begin
            cnt_d        = at_last_s ? MAX_C : (cnt_q + ONE_C);
            prefer_cpu_d = at_last_s;
        end else if (clr_s) begin
            cnt_d = {CW{1'b0}};
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter and release-flag registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q        <= {CW{1'b0}};
            prefer_cpu_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            prefer_cpu_q <= prefer_cpu_d;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates a single-ported synchronous memory between the CPU (port 0) and DMA (port 1).
// Define ARB_ROUND_ROBIN_EN for round-robin contention; otherwise the CPU wins contention.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int LOCK_MAX = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        req,
    input  logic [1:0]        lock,
    input  logic [2*AW-1:0]   addr,
    input  logic [2*DW-1:0]   wdata,
    input  logic [2*BE_W-1:0] we,
    output logic [1:0]        gnt,
    output logic [1:0]        rvalid,
    output logic [DW-1:0]     rdata,
    output logic [AW-1:0]     maddr,
    output logic [DW-1:0]     mwdata,
    output logic [BE_W-1:0]   mwe,
    output logic              mre,
    input  logic [DW-1:0]     mrdata
);
    arb_state_e state_q;
    arb_state_e state_d;
    logic [1:0] gnt_s;
    logic [1:0] rvalid_q;
    logic [1:0] rvalid_d;
    logic       open_arb_s;
    logic       cnt_clr_s;
    logic       cnt_load_s;
    logic       cnt_inc_s;
    logic       cnt_at_last_s;
    logic       prefer_cpu_q;
    logic       contend_pick_s;
    logic       lock_cpu_unused_s;

    // The CPU port has no lock capability.
    assign lock_cpu_unused_s = lock[PORT_CPU];

    arb_lock_counter #(
        .LOCK_MAX (LOCK_MAX)
    ) u_lock_cnt (
        .clk          (clk),
        .reset        (reset),
        .clr_s        (cnt_clr_s),
        .load_s       (cnt_load_s),
        .inc_s        (cnt_inc_s),
        .at_last_s    (cnt_at_last_s),
        .prefer_cpu_q (prefer_cpu_q)
    );

`ifdef ARB_ROUND_ROBIN_EN
    logic prio_q;
    logic prio_d;

    assign contend_pick_s = prio_q;

    // The pointer names the port that was not granted most recently.
    always_comb begin
        if (gnt[PORT_CPU]) begin
            prio_d = PORT_DMA;
        end else if (gnt[PORT_DMA]) begin
            prio_d = PORT_CPU;
        end else begin
            prio_d = prio_q;
        end
    end

    // Round-robin pointer register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prio_q <= PORT_CPU;
        end else begin
            prio_q <= prio_d;
        end
    end
`else
    assign contend_pick_s = PORT_CPU;
`endif

    // Grant selection, lock state machine and lock-counter controls.
    always_comb begin
        state_d    = state_q;
        gnt_s      = 2'b00;
        open_arb_s = 1'b0;
        cnt_clr_s  = 1'b0;
        cnt_load_s = 1'b0;
        cnt_inc_s  = 1'b0;
        case (state_q)
            LOCK1: begin
                if (req[PORT_DMA] && lock[PORT_DMA]) begin
                    gnt_s     = 2'b10;
                    cnt_inc_s = 1'b1;
                    state_d   = cnt_at_last_s ? OPEN : LOCK1;
                end else begin
                    // Lock dropped: this same cycle is arbitrated as OPEN.
                    open_arb_s = 1'b1;
                    cnt_clr_s  = 1'b1;
                    state_d    = OPEN;
                end
            end
            OPEN: begin
                open_arb_s = 1'b1;
            end
            default: begin
                open_arb_s = 1'b1;
                state_d    = OPEN;
            end
        endcase
        if (open_arb_s) begin
            case (req)
                2'b01:   gnt_s = 2'b01;
                2'b10:   gnt_s = 2'b10;
                2'b11:   gnt_s = (prefer_cpu_q || (contend_pick_s == PORT_CPU)) ? 2'b01 : 2'b10;
                default: gnt_s = 2'b00;
            endcase
            if (gnt_s[PORT_DMA] && lock[PORT_DMA]) begin
                cnt_load_s = 1'b1;
                state_d    = (LOCK_MAX <= 1) ? OPEN : LOCK1;
            end else begin
                state_d = OPEN;
            end
        end else begin
            cnt_load_s = 1'b0;
        end
    end

    assign gnt    = reset ? gnt_s : 2'b00;
    assign rvalid = rvalid_q;
    assign rdata  = mrdata;

    // Memory strobes muxed from the granted port, and the read-owner capture.
    always_comb begin
        maddr    = {AW{1'b0}};
        mwdata   = {DW{1'b0}};
        mwe      = {BE_W{1'b0}};
        if (gnt[PORT_DMA]) begin
            maddr  = addr[AW +: AW];
            mwdata = wdata[DW +: DW];
            mwe    = we[BE_W +: BE_W];
        end else if (gnt[PORT_CPU]) begin
            maddr  = addr[0 +: AW];
            mwdata = wdata[0 +: DW];
            mwe    = we[0 +: BE_W];
        end else begin
            maddr  = {AW{1'b0}};
        end
        mre      = (gnt != 2'b00) && (mwe == {BE_W{1'b0}});
        rvalid_d = mre ? gnt : 2'b00;
    end

    // Arbiter state and read-valid registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= OPEN;
            rvalid_q <= 2'b00;
        end else begin
            state_q  <= state_d;
            rvalid_q <= rvalid_d;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: single-cycle vector table plus multi-cycle
// sequences for contention, locked bursts, forced release and reset during a read.
module tb_mem_port_arbiter;

    localparam logic [31:0] K = 32'hA5A5_0F0F;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  req;
    logic [1:0]  lock;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [7:0]  we;
    logic [1:0]  gnt;
    logic [1:0]  rvalid;
    logic [31:0] rdata;
    logic [31:0] maddr;
    logic [31:0] mwdata;
    logic [3:0]  mwe;
    logic        mre;
    logic [31:0] mrdata = 32'h0;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [1:0]  req;
        logic [1:0]  lock;
        logic [31:0] a0;
        logic [31:0] a1;
        logic [31:0] w0;
        logic [31:0] w1;
        logic [3:0]  be0;
        logic [3:0]  be1;
        logic [1:0]  gnt;
        logic [31:0] maddr;
        logic [31:0] mwdata;
        logic [3:0]  mwe;
        logic        mre;
        logic [1:0]  rv;
    } vec_t;

    vec_t vt [7];

    mem_port_arbiter #(
        .AW       (32),
        .DW       (32),
        .LOCK_MAX (16)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .req    (req),
        .lock   (lock),
        .addr   (addr),
        .wdata  (wdata),
        .we     (we),
        .gnt    (gnt),
        .rvalid (rvalid),
        .rdata  (rdata),
        .maddr  (maddr),
        .mwdata (mwdata),
        .mwe    (mwe),
        .mre    (mre),
        .mrdata (mrdata)
    );

    always #5 clk = ~clk;

    // Memory model: read data is a known function of the address, one cycle later.
    always @(posedge clk) begin
        if (mre) mrdata <= maddr ^ K;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // One cycle: drive req/lock, check grant mid-cycle, check rvalid after the edge.
    task automatic step(input string nm, input logic [1:0] r, input logic [1:0] l,
                        input logic [1:0] eg, input logic [1:0] erv);
        req  = r;
        lock = l;
        @(negedge clk);
        chk({nm, "_gnt"}, {62'd0, gnt}, {62'd0, eg});
        @(posedge clk);
        #1;
        chk({nm, "_rvalid"}, {62'd0, rvalid}, {62'd0, erv});
    endtask

    task automatic lock_run(input int run);
        step($sformatf("lmax%0d_c1", run), 2'b10, 2'b10, 2'b10, 2'b00);
        for (int c = 2; c <= 16; c++) begin
            step($sformatf("lmax%0d_c%0d", run, c), 2'b11, 2'b10, 2'b10, 2'b00);
        end
        step($sformatf("lmax%0d_c17", run), 2'b11, 2'b10, 2'b01, 2'b01);
    endtask

    initial begin
        logic [1:0] exp_g;

        //         req    lock   a0          a1          w0            w1            be0   be1    gnt    maddr       mwdata        mwe   mre   rv
        vt[0] = '{2'b01, 2'b00, 32'h100,    32'h204,    32'h0,        32'h55,       4'h0, 4'h0,  2'b01, 32'h100,    32'h0,        4'h0, 1'b1, 2'b01};
        vt[1] = '{2'b10, 2'b00, 32'h108,    32'h200,    32'h77,       32'h11112222, 4'hF, 4'h0,  2'b10, 32'h200,    32'h11112222, 4'h0, 1'b1, 2'b10};
        vt[2] = '{2'b01, 2'b00, 32'h104,    32'h208,    32'hDEADBEEF, 32'h99,       4'h3, 4'hC,  2'b01, 32'h104,    32'hDEADBEEF, 4'h3, 1'b0, 2'b00};
        vt[3] = '{2'b10, 2'b00, 32'h10C,    32'h20C,    32'h1,        32'hCAFEF00D, 4'h0, 4'hF,  2'b10, 32'h20C,    32'hCAFEF00D, 4'hF, 1'b0, 2'b00};
        vt[4] = '{2'b00, 2'b00, 32'h110,    32'h210,    32'h123,      32'h456,      4'h1, 4'h2,  2'b00, 32'h0,      32'h0,        4'h0, 1'b0, 2'b00};
        vt[5] = '{2'b01, 2'b01, 32'h114,    32'h214,    32'hAB,       32'hCD,       4'h0, 4'h0,  2'b01, 32'h114,    32'hAB,       4'h0, 1'b1, 2'b01};
        vt[6] = '{2'b10, 2'b01, 32'h118,    32'h218,    32'hEF,       32'h3C,       4'h0, 4'h0,  2'b10, 32'h218,    32'h3C,       4'h0, 1'b1, 2'b10};

        // Reset: grant and strobes forced off even with requests present.
        reset = 1'b0;
        req   = 2'b11;
        lock  = 2'b00;
        addr  = {32'h40, 32'h20};
        wdata = {32'h1, 32'h2};
        we    = 8'hFF;
        #2;
        chk("rst_gnt", {62'd0, gnt}, 64'd0);
        chk("rst_mwe", {60'd0, mwe}, 64'd0);
        chk("rst_rvalid", {62'd0, rvalid}, 64'd0);
        we = 8'h00;
        #1;
        chk("rst_mre", {63'd0, mre}, 64'd0);
        req = 2'b00;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 7; i++) begin
            req   = vt[i].req;
            lock  = vt[i].lock;
            addr  = {vt[i].a1, vt[i].a0};
            wdata = {vt[i].w1, vt[i].w0};
            we    = {vt[i].be1, vt[i].be0};
            @(negedge clk);
            chk($sformatf("v%0d_gnt", i),    {62'd0, gnt},    {62'd0, vt[i].gnt});
            chk($sformatf("v%0d_maddr", i),  {32'd0, maddr},  {32'd0, vt[i].maddr});
            chk($sformatf("v%0d_mwdata", i), {32'd0, mwdata}, {32'd0, vt[i].mwdata});
            chk($sformatf("v%0d_mwe", i),    {60'd0, mwe},    {60'd0, vt[i].mwe});
            chk($sformatf("v%0d_mre", i),    {63'd0, mre},    {63'd0, vt[i].mre});
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_rvalid", i), {62'd0, rvalid}, {62'd0, vt[i].rv});
            if (vt[i].rv != 2'b00) begin
                chk($sformatf("v%0d_rdata", i), {32'd0, rdata}, {32'd0, vt[i].maddr ^ K});
            end
        end

        // Continuous contention from a freshly reset pointer.
        reset = 1'b0;
        #2;
        reset = 1'b1;
        addr  = {32'h400, 32'h300};
        we    = 8'h00;
        for (int c = 0; c < 6; c++) begin
`ifdef ARB_ROUND_ROBIN_EN
            exp_g = (c % 2 == 0) ? 2'b01 : 2'b10;
`else
            exp_g = 2'b01;
`endif
            step($sformatf("contend_c%0d", c), 2'b11, 2'b00, exp_g, exp_g);
        end

        // Locked burst of DMA writes, CPU joins and waits, lock drop hands over.
        we = {4'hF, 4'h0};
        step("burst_c1", 2'b10, 2'b10, 2'b10, 2'b00);
        for (int c = 2; c <= 4; c++) begin
            step($sformatf("burst_c%0d", c), 2'b11, 2'b10, 2'b10, 2'b00);
        end
        step("burst_c5", 2'b11, 2'b00, 2'b01, 2'b01);

        // Lock released by DMA dropping its request.
        step("reqdrop_c1", 2'b10, 2'b10, 2'b10, 2'b00);
        step("reqdrop_c2", 2'b01, 2'b10, 2'b01, 2'b01);

        // Watchdog forced release, twice to confirm the count restarts.
        lock_run(1);
        lock_run(2);

        // Reset in the cycle after a granted read while locked.
        we = {4'hF, 4'h0};
        step("rstrd_lock", 2'b10, 2'b10, 2'b10, 2'b00);
        we = 8'h00;
        step("rstrd_read", 2'b11, 2'b10, 2'b10, 2'b10);
        we = 8'hFF;
        #2;
        reset = 1'b0;
        #1;
        chk("rstrd_rvalid", {62'd0, rvalid}, 64'd0);
        chk("rstrd_gnt",    {62'd0, gnt},    64'd0);
        chk("rstrd_mwe",    {60'd0, mwe},    64'd0);
        req = 2'b00;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        we = 8'h00;
        step("rstrd_post", 2'b11, 2'b10, 2'b01, 2'b01);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one synchronous single-ported memory between two requesters: port 0 is the CPU data port and port 1 is the program loader/DMA. The block sits between the CPU's daddr/dwdata/dwe/drdata bus and the physical memory. It grants at most one access per cycle and routes the one-cycle-late read data back to the port that issued the read. Port 1 may lock the memory for bursts, bounded by a watchdog counter; a port with request high and no grant is expected to stall.

## Interface
- AW, 32, address width
- DW, 32, data width; byte enables are DW/8 = 4 bits per port
- LOCK_MAX, 16, maximum consecutive locked grants before forced release
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-low; low clears all state immediately
- req  in  2  per-port request, bit n = port n
- lock  in  2  per-port lock request, meaningful only while that port is granted
- addr  in  2*AW  per-port byte address, port n in bits [n*AW +: AW]
- wdata  in  2*DW  per-port write data
- we  in  8  per-port byte enables, [n*4 +: 4]; 0 = read
- gnt  out  2  one-hot or zero grant, combinational, same cycle as req
- rvalid  out  2  registered: bit n high one cycle after a granted read by port n
- rdata  out  DW  read data, equals mrdata
- maddr  out  AW  memory address
- mwdata  out  DW  memory write data
- mwe  out  4  memory byte write enables
- mre  out  1  memory read enable
- mrdata  in  DW  memory read data, valid one cycle after mre

## Operation
- Arbiter states: OPEN, LOCK1. Port 0 has no lock; lock[0] is ignored.
- OPEN: if exactly one port requests, grant it. If both request, grant per the priority rule (see Configuration).
- Granting port 1 with lock[1]=1 moves OPEN to LOCK1 and sets the lock counter to 1.
- LOCK1: only port 1 may be granted. The counter increments on each port-1 grant.
- LOCK1 exits to OPEN on the first cycle lock[1]=0 or req[1]=0; that cycle is arbitrated as OPEN.
- Forced release: when the counter reaches LOCK_MAX, the state returns to OPEN and the next cycle prefers port 0 regardless of mode.
- Memory outputs are muxed from the granted port: maddr, mwdata and mwe come from that port.
- mre = granted and the granted port's we == 0.
- With no grant: maddr=0, mwdata=0, mwe=0, mre=0.
- Read owner register: captures the granted index when mre=1. rvalid asserts for that owner the next cycle; it is otherwise 0.
- A new access may be granted every cycle, including back-to-back reads from different ports.
- Writes never produce rvalid.
- Reset values: state OPEN, counter 0, priority pointer at port 0, rvalid=00.
- While reset is low: gnt=00, mwe=0, mre=0.

## Timing
- Request to grant and to memory strobes: 0 cycles (combinational).
- Read latency: rvalid/rdata arrive exactly 1 cycle after the granted cycle.
- Simultaneous requests are handled by arbitration. A losing port must hold req, addr, wdata and we stable until granted.
- Reset asserted mid-read discards the outstanding read: rvalid drops asynchronously and is not replayed.
- The counter saturates at LOCK_MAX and never wraps.

## Configuration
- ARB_ROUND_ROBIN_EN defined: on contention in OPEN, grant the port not granted most recently; the pointer updates on every grant.
- ARB_ROUND_ROBIN_EN undefined: fixed priority, port 0 (CPU) always wins contention. The only exception is the post-forced-release cycle, which also favours port 0.

## Structure
- Shared package mem_arb_pkg holds the state enum (OPEN, LOCK1), the port index constants PORT_CPU=0 and PORT_DMA=1, and the byte-enable width localparam.
- One sub-module, arb_lock_counter, holds the saturating counter and forced-release flag, parameterised by LOCK_MAX.

## Test plan
- Read from port 0 only: req=01, addr0=0x100, we0=0 → gnt=01, mre=1, maddr=0x100 the same cycle; next cycle rvalid=01 and rdata=mrdata.
- Write from port 0: we0=0011, wdata0=0xDEADBEEF → mwe=0011, mwdata=0xDEADBEEF, mre=0, and rvalid stays 00.
- Both ports read continuously for 6 cycles:
  - With ARB_ROUND_ROBIN_EN: gnt=01,10,01,10,01,10 and rvalid follows one cycle later.
  - Without it: gnt=01 every cycle.
- Port 1 locked burst of 4 writes while port 0 requests: gnt=10 for 4 cycles, lock[1] drops on cycle 5, and gnt=01 on cycle 5.
- Port 1 holds lock past LOCK_MAX=16 while port 0 requests: 16 grants to port 1, then gnt=01 on cycle 17, and the state is OPEN.
- Reset pulled low in the cycle after a granted read: rvalid goes to 00 immediately; after release, the state is OPEN and the first contention grants port 0.
